// File: rtl/zone_frame_writer.sv
// zone_frame_writer: writes one frame of per-zone brightness into the idle half of a ping-pong SRAM, then flips sdbpflag
// Optional feature macro: ZW_CLAMP_EN (clamps written data to MAX_LEVEL)
// Ports:
//   clka        write-domain clock, rising edge
//   rst_n       asynchronous active-low reset
//   s_valid     input beat valid
//   s_ready     block can accept a beat (low only in DONE)
//   s_data      zone brightness value
//   s_sof       beat is zone 0 of a new frame
//   wtena       SRAM write strobe, one cycle per write
//   wtaddr      SRAM write address (bank base + zone index)
//   wtdina      SRAM write data
//   sdbpflag    bank the reader uses; writer fills ~sdbpflag
//   frame_done  one-cycle pulse when sdbpflag flips
//   frame_err   one-cycle pulse when s_sof arrives mid-frame
//   zone_idx    next zone index to be written
module zone_frame_writer #(
   parameter int ZONE_NUM = 384,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int BANK_OFFSET = 512,
   parameter logic [DATA_W-1:0] MAX_LEVEL = 16'h0FFF
) (
   input  logic              clka,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sof,
   output logic              wtena,
   output logic [ADDR_W-1:0] wtaddr,
   output logic [DATA_W-1:0] wtdina,
   output logic              sdbpflag,
   output logic              frame_done,
   output logic              frame_err,
   output logic [ADDR_W-1:0] zone_idx
);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
   localparam logic [ADDR_W-1:0] BANK1 = ADDR_W'(BANK_OFFSET);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ZONE_NUM - 1);
`ifdef ZW_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif
   state_t state, state_n;
   logic [ADDR_W-1:0] idx_n, zone;
   logic [DATA_W-1:0] wdata;
   logic acc, wr, err;
   // held low during reset so every output reads 0 while rst_n is asserted
   assign s_ready = rst_n && state != DONE;
   assign acc = s_valid && s_ready;
   assign wdata = (CLAMP && s_data > MAX_LEVEL) ? MAX_LEVEL : s_data;
   always_comb begin
      state_n = state;
      idx_n = zone_idx;
      zone = zone_idx;
      wr = 1'b0;
      err = 1'b0;
      case (state)
         IDLE: if (acc && s_sof) begin
            wr = 1'b1;
            zone = '0;
            state_n = ZONE_NUM == 1 ? DONE : WRITE;
            idx_n = ZONE_NUM == 1 ? '0 : ADDR_W'(1);
         end
         WRITE: if (acc) begin
            wr = 1'b1;
            if (s_sof) begin
               // truncated frame: restart at zone 0 of the same bank
               err = 1'b1;
               zone = '0;
               idx_n = ADDR_W'(1);
            end else if (zone_idx == LAST) begin
               state_n = DONE;
               idx_n = '0;
            end else idx_n = zone_idx + 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         zone_idx <= '0;
         sdbpflag <= 1'b0;
         wtena <= 1'b0;
         wtaddr <= '0;
         wtdina <= '0;
         frame_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state <= state_n;
         zone_idx <= idx_n;
         wtena <= wr;
         frame_err <= err;
         // bank flips one cycle after the last write, so that write lands in the old bank
         frame_done <= state == DONE;
         sdbpflag <= sdbpflag ^ (state == DONE);
         if (wr) begin
            wtaddr <= (sdbpflag ? '0 : BANK1) + zone;
            wtdina <= wdata;
         end
      end
   end
endmodule

// File: doc/zone_frame_writer.md
Name: zone_frame_writer

Overview:
- Write-side producer for the zonal-backlight dual-port SRAM; runs in the clka domain and drives the port-A write bus (wtaddr/wtdina) that the read/latch side consumes.
- Accepts one frame of per-zone 16-bit brightness values over a valid/ready stream.
- Writes the values into the inactive half of a ping-pong SRAM, then flips sdbpflag so the reader switches banks.

Parameters:
- ZONE_NUM, 384, zones per frame; legal range 1..BANK_OFFSET.
- ADDR_W, 10, width of wtaddr.
- DATA_W, 16, width of zone data and wtdina.
- BANK_OFFSET, 512, address base of bank 1 (bank 0 base is 0); must be a power of two and ≤ 2^(ADDR_W-1).
- MAX_LEVEL, 16'h0FFF, clamp ceiling; used only with ZW_CLAMP_EN.

Ports:
- clka  in  1  write-domain clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  DATA_W  zone brightness value.
- s_sof  in  1  beat is zone 0 of a new frame; qualified by s_valid.
- wtena  out  1  SRAM write strobe, one cycle per write.
- wtaddr  out  ADDR_W  SRAM write address.
- wtdina  out  DATA_W  SRAM write data.
- sdbpflag  out  1  bank the reader should use; the writer fills the other bank (~sdbpflag).
- frame_done  out  1  one-cycle pulse when sdbpflag flips.
- frame_err  out  1  one-cycle pulse on a truncated frame, i.e. s_sof arrives mid-frame.
- zone_idx  out  ADDR_W  next zone index to be written (debug).

Behaviour:
- Reset (async assert, sync release): all outputs 0.
  - State IDLE, zone_idx 0, sdbpflag 0. The first frame therefore writes bank 1.
- A beat is accepted when s_valid and s_ready are both high on a clka edge.
- s_ready is 1 in IDLE and WRITE, and 0 in DONE.
- State machine:
  - IDLE: an accepted beat with s_sof=1 writes zone 0 and moves to WRITE, or to DONE if ZONE_NUM=1. An accepted beat with s_sof=0 is discarded: no write, no error.
  - WRITE: each accepted beat with s_sof=0 writes zone zone_idx and increments it. The beat that writes zone ZONE_NUM-1 moves to DONE.
  - WRITE, accepted beat with s_sof=1: pulse frame_err. That beat is written as zone 0 of the same bank, zone_idx becomes 1, and the state stays WRITE. sdbpflag does not toggle.
  - DONE: lasts exactly one cycle. sdbpflag toggles, frame_done pulses, next state IDLE.
- Write path is registered, with 1-cycle latency from the accepting edge to the visible outputs.
  - wtena=1.
  - wtaddr = (~sdbpflag ? BANK_OFFSET : 0) + zone index, computed in ADDR_W bits with no wrap. The parameter legality rules guarantee the sum fits.
  - wtdina = s_data, unless the optional feature modifies it.
  - With no accepted beat, wtena=0; wtaddr and wtdina hold their last values.
- Bank selection uses the sdbpflag value at the accepting edge. The last write of a frame always lands in the old write bank, because the toggle happens one cycle later in DONE.
- zone_idx wraps to 0 on entry to DONE; it never exceeds ZONE_NUM-1.
- Gaps (s_valid low) may occur anywhere mid-frame. The state is held indefinitely, with no timeout.
- A reset asserted mid-frame aborts the frame: no frame_done, sdbpflag returns to 0, and partial bank contents are left as-is.
- frame_done and frame_err are never high in the same cycle.

Optional Feature:
- Macro ZW_CLAMP_EN.
- Defined: wtdina = (s_data > MAX_LEVEL) ? MAX_LEVEL : s_data, using an unsigned compare inside the same register stage, so latency is unchanged.
- Undefined: wtdina = s_data unmodified, and MAX_LEVEL is ignored.

Test Plan:
- Reset, then one frame of ZONE_NUM=384 beats with data = zone index and no gaps → 384 wtena pulses, wtaddr 512..895, wtdina 0..383. One cycle after the last write, frame_done=1 and sdbpflag=1.
- Second identical frame → wtaddr 0..383, then sdbpflag returns to 0. A beat offered during DONE sees s_ready=0 and is not written.
- s_sof at zone 100 of a frame → frame_err pulses once and that beat is written to wtaddr 512. Completing 383 further beats produces frame_done with wtaddr ending at 895.
- Beats with s_sof=0 after reset, before any sof → no wtena, no error, s_ready stays 1. Random s_valid gaps mid-frame still give exactly 384 in-order writes.
- rst_n pulled low at zone 200 → all outputs 0 asynchronously. The next full frame writes bank 1 (base 512).
- With ZW_CLAMP_EN defined and MAX_LEVEL=0x0FFF, s_data 0x8000 → wtdina 0x0FFF, while s_data 0x0ABC passes as 0x0ABC. With the macro undefined, 0x8000 passes unchanged.
